servo_pwm_multi: RTL and testbench

Parametrised multi-channel servo/ESC PWM generator, successor to the single-channel `pid_tim` timer. It produces CHANNELS hobby-servo style pulse outputs that share one frame timebase. Each channel takes a pulse width in microseconds, clamps it to a legal range, and applies it only at frame boundaries through shadow registers. Optional per-frame slew limiting is available. It sits between the PID/AXI control logic and the actuator pins.

---
 rtl/servo_pwm_pkg.sv | 30 +++
 rtl/servo_pwm_multi_if.sv | 15 +
 rtl/servo_pwm_chan.sv | 54 +++++
 rtl/servo_pwm_multi.sv | 75 +++++++
 tb/tb_servo_pwm_multi.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pwm_pkg.sv
// Shared widths, clamp and slew helpers for the multi-channel servo PWM generator.
// Pure functions only; no state, no latency, no backpressure.
package servo_pwm_pkg;

  function automatic int us_cnt_w(input int period_us);
    return (period_us > 1) ? $clog2(period_us) : 1;
  endfunction

  function automatic int pre_w(input int clk_mhz);
    return (clk_mhz > 1) ? $clog2(clk_mhz) : 1;
  endfunction

  function automatic logic [31:0] clamp_us(input logic [31:0] v,
                                           input logic [31:0] lo,
                                           input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Moves cur towards tgt by at most step; a zero step jumps straight to tgt.
  function automatic logic [31:0] slew_step(input logic [31:0] cur,
                                            input logic [31:0] tgt,
                                            input logic [31:0] step);
    if (step == 32'd0) return tgt;
    if (tgt > cur) return ((tgt - cur) > step) ? cur + step : tgt;
    return ((cur - tgt) > step) ? cur - step : tgt;
  endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Control and pulse-output bundle between the PID/AXI side and the servo PWM block.
// Writes are single-cycle strobes with no backpressure; outputs are free-running.
interface servo_pwm_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CTRL_W   = 16
);
  logic [CHANNELS*CTRL_W-1:0] ctrl_value;
  logic [CHANNELS-1:0]        ctrl_valid;
  logic [CHANNELS-1:0]        ch_enable;
  logic [CHANNELS-1:0]        pwm;
  logic                       frame_start;

  modport master (output ctrl_value, ctrl_valid, ch_enable, input pwm, frame_start);
  modport slave  (input ctrl_value, ctrl_valid, ch_enable, output pwm, frame_start);
endinterface

// File: rtl/servo_pwm_chan.sv
// One PWM channel: clamped pending width, frame-aligned shadow load with optional slew.
// Output registered, pulse starts one cycle after frame start; writes are never stalled.
module servo_pwm_chan
  import servo_pwm_pkg::*;
#(
  parameter int CTRL_W   = 16,
  parameter int US_CNT_W = 15,
  parameter int MIN_US   = 500,
  parameter int MAX_US   = 2500,
  parameter int RESET_US = 1500,
  parameter int SLEW_US  = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                fs,
  input  logic [US_CNT_W-1:0] frame_us,
  input  logic [CTRL_W-1:0]   ctrl_value,
  input  logic                ctrl_valid,
  input  logic                ch_enable,
  output logic                pwm
);

  logic [CTRL_W-1:0] pending;
  logic [CTRL_W-1:0] active;
  logic [CTRL_W-1:0] active_next;
  logic              en_q;
  logic              en_next;

  // Shadow values only move at the frame boundary so a pulse in flight is never reshaped.
  always_comb begin
    active_next = active;
    en_next     = en_q;
    if (fs) begin
      en_next     = ch_enable;
      active_next = CTRL_W'(slew_step(32'(active), 32'(pending), 32'(SLEW_US)));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pending <= CTRL_W'(RESET_US);
      active  <= CTRL_W'(RESET_US);
      en_q    <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      if (ctrl_valid)
        pending <= CTRL_W'(clamp_us(32'(ctrl_value), 32'(MIN_US), 32'(MAX_US)));
      active <= active_next;
      en_q   <= en_next;
      pwm    <= en_next && (32'(frame_us) < 32'(active_next));
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared microsecond prescaler and frame counter feeding per-channel units.
// New widths take effect at the next frame start plus one cycle; inputs are never backpressured.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int CLK_VAL_MHZ = 50,
  parameter int CHANNELS    = 4,
  parameter int CTRL_W      = 16,
  parameter int PERIOD_US   = 20000,
  parameter int MIN_US      = 500,
  parameter int MAX_US      = 2500,
  parameter int RESET_US    = 1500,
  parameter int SLEW_US     = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  servo_pwm_multi_if.slave  bus
);

  localparam int US_CNT_W = us_cnt_w(PERIOD_US);
  localparam int PRE_W    = pre_w(CLK_VAL_MHZ);

  if (!(MIN_US <= RESET_US && RESET_US <= MAX_US && MAX_US < PERIOD_US &&
        (MAX_US >> CTRL_W) == 0 && CHANNELS >= 1 && CHANNELS <= 16)) begin : g_param_err
    $error("servo_pwm_multi: illegal parameter combination");
  end

  logic [PRE_W-1:0]    pre;
  logic [US_CNT_W-1:0] frame_us;
  logic                us_tick;
  logic                fs;
  logic                frame_start_q;
  logic [CHANNELS-1:0] pwm_q;

  assign us_tick = (pre == PRE_W'(CLK_VAL_MHZ - 1));
  // Reset leaves both counters at zero, so the first cycle after release is a frame start.
  assign fs      = (pre == '0) && (frame_us == '0);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pre           <= '0;
      frame_us      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pre           <= us_tick ? '0 : pre + PRE_W'(1);
      frame_start_q <= fs;
      if (us_tick)
        frame_us <= (frame_us == US_CNT_W'(PERIOD_US - 1)) ? '0 : frame_us + US_CNT_W'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    servo_pwm_chan #(
      .CTRL_W   (CTRL_W),
      .US_CNT_W (US_CNT_W),
      .MIN_US   (MIN_US),
      .MAX_US   (MAX_US),
      .RESET_US (RESET_US),
      .SLEW_US  (SLEW_US)
    ) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .fs         (fs),
      .frame_us   (frame_us),
      .ctrl_value (bus.ctrl_value[k*CTRL_W +: CTRL_W]),
      .ctrl_valid (bus.ctrl_valid[k]),
      .ch_enable  (bus.ch_enable[k]),
      .pwm        (pwm_q[k])
    );
  end

  assign bus.pwm         = pwm_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: an unslewed and a slewed instance driven by identical stimulus,
// each measured frame by frame against a per-frame width model.
module tb_servo_pwm_multi;

  localparam int CLK  = 2;
  localparam int PER  = 100;
  localparam int MINU = 10;
  localparam int MAXU = 50;
  localparam int RSTU = 30;
  localparam int CH   = 4;
  localparam int W    = 16;
  localparam int F    = PER * CLK;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [CH*W-1:0] value;
  logic [CH-1:0]   valid;
  logic [CH-1:0]   enable;

  servo_pwm_multi_if #(.CHANNELS(CH), .CTRL_W(W)) bus0 ();
  servo_pwm_multi_if #(.CHANNELS(CH), .CTRL_W(W)) bus1 ();

  assign bus0.ctrl_value = value;
  assign bus0.ctrl_valid = valid;
  assign bus0.ch_enable  = enable;
  assign bus1.ctrl_value = value;
  assign bus1.ctrl_valid = valid;
  assign bus1.ch_enable  = enable;

  servo_pwm_multi #(
    .CLK_VAL_MHZ(CLK), .CHANNELS(CH), .CTRL_W(W), .PERIOD_US(PER),
    .MIN_US(MINU), .MAX_US(MAXU), .RESET_US(RSTU), .SLEW_US(0)
  ) u_dut0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus0));

  servo_pwm_multi #(
    .CLK_VAL_MHZ(CLK), .CHANNELS(CH), .CTRL_W(W), .PERIOD_US(PER),
    .MIN_US(MINU), .MAX_US(MAXU), .RESET_US(RSTU), .SLEW_US(4)
  ) u_dut1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus1));

  logic [CH-1:0] pwm_d [2];
  logic          fs_d  [2];
  assign pwm_d[0] = bus0.pwm;
  assign pwm_d[1] = bus1.pwm;
  assign fs_d[0]  = bus0.frame_start;
  assign fs_d[1]  = bus1.frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference state: requested and applied widths in microseconds, per instance and channel.
  int pend   [2][CH];
  int act_us [2][CH];
  int lat_w  [2][CH];
  int obs_w  [2][CH];
  int hi_cnt [2][CH];
  int last_hi[2][CH];
  int fs_cnt [2];
  int meas   [2][16][CH];
  int c;
  int frame_no;
  bit have_frame;

  function automatic int slew_of(input int d);
    return (d == 0) ? 0 : 4;
  endfunction

  function automatic int clamp_m(input int v);
    if (v < MINU) return MINU;
    if (v > MAXU) return MAXU;
    return v;
  endfunction

  function automatic int approach(input int cur, input int tgt, input int s);
    if (s == 0) return tgt;
    if (tgt - cur > s) return cur + s;
    if (cur - tgt > s) return cur - s;
    return tgt;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < CH; k++) begin
        pend[d][k]   = RSTU;
        act_us[d][k] = RSTU;
      end
    have_frame = 0;
    frame_no   = -1;
    c          = 0;
  endtask

  task automatic finish_frame();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("fs_count d%0d f%0d", d, frame_no), fs_cnt[d], 1);
      for (int k = 0; k < CH; k++) begin
        chk($sformatf("width d%0d ch%0d f%0d", d, k, frame_no), hi_cnt[d][k], obs_w[d][k]);
        chk($sformatf("pulse_end d%0d ch%0d f%0d", d, k, frame_no), last_hi[d][k] + 1, obs_w[d][k]);
        if (frame_no >= 0 && frame_no < 16) meas[d][frame_no][k] = hi_cnt[d][k];
      end
    end
  endtask

  // Advances one clock: the model consumes this cycle's inputs, then outputs are observed.
  task automatic cycle();
    int off;
    if (c % F == 0)
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < CH; k++) begin
          act_us[d][k] = approach(act_us[d][k], pend[d][k], slew_of(d));
          lat_w[d][k]  = enable[k] ? act_us[d][k] * CLK : 0;
        end
    for (int k = 0; k < CH; k++)
      if (valid[k])
        for (int d = 0; d < 2; d++) pend[d][k] = clamp_m(int'(value[k*W +: W]));
    @(posedge sys_clk);
    @(negedge sys_clk);
    valid = '0;
    off = c % F;
    if (off == 0) begin
      if (have_frame) finish_frame();
      have_frame = 1;
      frame_no++;
      for (int d = 0; d < 2; d++) begin
        fs_cnt[d] = 0;
        chk($sformatf("frame_start_at_fs d%0d f%0d", d, frame_no), 32'(fs_d[d]), 1);
        for (int k = 0; k < CH; k++) begin
          obs_w[d][k]   = lat_w[d][k];
          hi_cnt[d][k]  = 0;
          last_hi[d][k] = -1;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (fs_d[d] === 1'b1) fs_cnt[d]++;
      for (int k = 0; k < CH; k++)
        if (pwm_d[d][k] === 1'b1) begin
          hi_cnt[d][k]++;
          last_hi[d][k] = off;
        end
    end
    c++;
  endtask

  task automatic run_to(input int target);
    while (c < target) cycle();
  endtask

  task automatic wr(input int k, input int v);
    value[k*W +: W] = W'(v);
    valid[k] = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s pwm d%0d", tag, d), 32'(pwm_d[d]), 0);
      chk($sformatf("%s frame_start d%0d", tag, d), 32'(fs_d[d]), 0);
    end
  endtask

  int slew_tab[5] = '{34, 38, 42, 45, 45};
  int bvals[6]    = '{0, 9, 10, 50, 51, 65535};

  initial begin
    value  = '0;
    valid  = '0;
    enable = '1;
    sys_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk_reset_outputs("in_reset");
    end

    // Directed frames: mid-frame write, clamps, write on the frame-start cycle, enable drop.
    sys_rst_n = 1'b1;
    model_reset();
    run_to(50);
    wr(1, 45);
    run_to(F + 37);
    wr(0, 0);
    wr(2, 65535);
    run_to(2 * F);
    wr(3, 20);
    run_to(4 * F + 10);
    enable[3] = 1'b0;
    run_to(6 * F + 20);

    for (int k = 0; k < CH; k++) chk($sformatf("dir f0 ch%0d", k), meas[0][0][k], 60);
    chk("dir f1 ch1 mid_write", meas[0][1][1], 90);
    chk("dir f1 ch0 untouched", meas[0][1][0], 60);
    chk("dir f1 ch3 untouched", meas[0][1][3], 60);
    chk("dir f2 ch0 clamp_lo", meas[0][2][0], 20);
    chk("dir f2 ch2 clamp_hi", meas[0][2][2], 100);
    chk("dir f2 ch3 fs_write_deferred", meas[0][2][3], 60);
    chk("dir f3 ch3 fs_write_applied", meas[0][3][3], 40);
    chk("dir f4 ch3 en_drop_completes", meas[0][4][3], 40);
    chk("dir f5 ch3 disabled", meas[0][5][3], 0);
    chk("dir slew f0 ch1", meas[1][0][1], 60);
    for (int i = 0; i < 5; i++)
      chk($sformatf("dir slew f%0d ch1", i + 1), meas[1][i + 1][1], slew_tab[i] * CLK);
    chk("dir slew f3 ch3", meas[1][3][3], 26 * CLK);

    // Reset while pulses are high: outputs must drop on the very next edge.
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk_reset_outputs("mid_pulse_reset");
    @(negedge sys_clk);
    enable = '1;
    sys_rst_n = 1'b1;
    model_reset();
    run_to(F + 1);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < CH; k++)
        chk($sformatf("after_reset d%0d ch%0d", d, k), meas[d][0][k], RSTU * CLK);

    // Random writes, boundary values, frame-start-cycle writes and enable toggles.
    while (c < 14 * F + 1) begin
      if ($urandom_range(0, 47) == 0 || (c % F == 0 && $urandom_range(0, 1) == 0)) begin
        int k;
        int v;
        k = int'($urandom_range(0, CH - 1));
        v = ($urandom_range(0, 2) == 0) ? bvals[$urandom_range(0, 5)] : int'($urandom_range(0, 80));
        wr(k, v);
      end
      if ($urandom_range(0, 299) == 0) enable[$urandom_range(0, CH - 1)] ^= 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
